datamem_ws: RTL

- Parametrised, word-addressed data memory with a req/ack handshake and a configurable number of wait states.
- Replaces the combinational-read, write-on-strobe data memory in the multicycle datapath, so the microcode controller must stall on memory accesses.
- Adds byte-enabled writes, out-of-range error reporting, and generic data/address widths and depth.

---
 rtl/datamem_pkg.sv | 27 ++
 rtl/datamem_array.sv | 39 +++
 rtl/datamem_ws.sv | 138 +++++++++++++
 3 files changed

// File: rtl/datamem_pkg.sv
// Shared types, default sizes and helper sizing functions for the
// wait-stated data memory.
package datamem_pkg;

    // Handshake sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_STATES = 2;

    // Bits needed to hold a count of 0..ws, never less than one bit.
    function automatic int cnt_width(input int ws);
        return (ws < 2) ? 1 : $clog2(ws + 1);
    endfunction

    // Bits needed to index depth words, never less than one bit.
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/datamem_array.sv
// DEPTH x DATA_W storage: synchronous byte-enabled write port and a
// synchronous read port. Every word starts at INIT_VAL.
module datamem_array
    import datamem_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = 'hAC,
    localparam int              IDX_W    = idx_width(DEPTH),
    localparam int              NB       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    // Byte-lane writes and registered read of the addressed word.
    // NOTE: no reset here on purpose -- storage contents must survive rst_n,
    // and a reset on a RAM array prevents it mapping onto block memory.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            q <= mem[idx];
        end
    end

endmodule

// File: rtl/datamem_ws.sv
// Word-addressed data memory with req/ack handshake, WAIT_STATES extra
// cycles per access, byte-enabled writes and out-of-range error reporting.
module datamem_ws
    import datamem_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DEPTH       = DEF_DEPTH,
    parameter int                WAIT_STATES = DEF_WAIT_STATES,
    parameter logic [DATA_W-1:0] INIT_VAL    = 'hAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                busy,
    output logic                ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = cnt_width(WAIT_STATES);
    localparam int IDX_W = idx_width(DEPTH);
    // Wide enough to hold both the full address and DEPTH, so every upper
    // address bit takes part in the range check.
    localparam int CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;
    logic                err_q;
    logic                rd_zero_q;
    logic [DATA_W-1:0]   mem_q;

    logic                accept;
    logic                access;
    logic                in_range;
    logic                mem_we;
    logic                mem_re;

    assign in_range = (CMP_W'(addr_q) < CMP_W'(DEPTH));
    assign mem_we   = access &  we_q & in_range;
    assign mem_re   = access & ~we_q & in_range;

    // State register; reset drops busy/ack at once since both decode state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        ack     = 1'b0;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                accept = req;
                if (req) state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ack     = 1'b1;
                accept  = req;
                state_d = req ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches, wait counter and response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
                cnt_q   <= CNT_W'(WAIT_STATES);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (access) begin
                err_q <= ~in_range;
                // Only reads move rdata; an out-of-range read forces it to 0.
                if (!we_q) rd_zero_q <= ~in_range;
            end
        end
    end

    assign err   = err_q;
    assign rdata = rd_zero_q ? '0 : mem_q;

    datamem_array #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (be_q),
        .idx   (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .re    (mem_re),
        .q     (mem_q)
    );

endmodule
